// File: rtl/gate3_pkg.sv
// Shared types and constants for the 3-input gate response checker.
//   state_e : checker FSM states
//   VEC_W / ERR_W / CNT_W : vector, error-count and settle-counter widths
//   *_TT    : truth tables, bit i = expected output for vector i = {a,b,c}
package gate3_pkg;

  localparam int unsigned VEC_W = 3;
  localparam int unsigned ERR_W = 4;
  localparam int unsigned CNT_W = 4;

  localparam logic [7:0] AND3_TT = 8'h80;
  localparam logic [7:0] OR3_TT  = 8'hFE;
  localparam logic [7:0] XOR3_TT = 8'h96;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2
  } state_e;

endpackage

// File: rtl/gate3_response_checker.sv
// Sweeps all eight input vectors of a 3-input combinational gate, samples its
// output after a programmable settle interval and compares it against a truth
// table. Reports pass/fail, mismatch count and the first failing vector.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : begin a sweep (sampled only while idle)
//   d                 : gate output under check
//   a, b, c           : gate inputs, {a,b,c} = current vector
//   busy              : sweep in progress
//   done              : one-cycle pulse when the verdict is final
//   pass              : last sweep had zero mismatches (held until next start)
//   err_count         : mismatches in the last sweep (0..8)
//   first_fail_vec    : first mismatching vector
//   first_fail_valid  : first_fail_vec is meaningful
module gate3_response_checker
  import gate3_pkg::*;
#(
  parameter logic [7:0]  EXPECTED = AND3_TT,
  parameter int unsigned SETTLE   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             d,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic             first_fail_valid
);

  // SETTLE+1 cycles per vector: reload value counts down to zero, then sample.
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);
  localparam logic [VEC_W-1:0] VEC_LAST   = VEC_W'(7);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [VEC_W-1:0] ffv_q, ffv_d;
  logic             ffvalid_q, ffvalid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic             mismatch;
  logic [ERR_W-1:0] err_inc;

  // Response compare against the truth-table bit for the current vector.
  assign mismatch = (d != EXPECTED[vec_q]);
  assign err_inc  = err_q + ERR_W'(mismatch);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      vec_q     <= '0;
      cnt_q     <= '0;
      err_q     <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          vec_d     = '0;
          cnt_d     = CNT_RELOAD;
          err_d     = '0;
          pass_d    = 1'b0;
          ffvalid_d = 1'b0;
          ffv_d     = '0;
          busy_d    = 1'b1;
          state_d   = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_SAMPLE: begin
        err_d = err_inc;
        if (mismatch && !ffvalid_q) begin
          ffv_d     = vec_q;
          ffvalid_d = 1'b1;
        end
        if (vec_q == VEC_LAST) begin
          // Verdict includes a mismatch on the final vector.
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_inc == '0);
        end else begin
          vec_d   = vec_q + VEC_W'(1);
          cnt_d   = CNT_RELOAD;
          state_d = ST_SETTLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign {a, b, c}        = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_gate3_response_checker.sv
// Bench for gate3_response_checker: four checker instances with different
// truth tables / settle intervals, each driven by a table-defined model gate.
module tb_gate3_response_checker;
  import gate3_pkg::*;

  localparam int NI = 4;
  localparam int unsigned S_TAB [NI] = '{2, 1, 1, 15};
  localparam logic [7:0]  E_TAB [NI] = '{AND3_TT, OR3_TT, AND3_TT, XOR3_TT};

  logic clk = 1'b0;
  logic rst_n;
  logic start_v [NI];
  logic d_v     [NI];
  logic a_v     [NI];
  logic b_v     [NI];
  logic c_v     [NI];
  logic busy_v  [NI];
  logic done_v  [NI];
  logic pass_v  [NI];
  logic ffval_v [NI];
  logic [3:0] err_v [NI];
  logic [2:0] ffv_v [NI];
  logic [7:0] g_tab [NI];

  // Reference model state: edge counter, start-capture edge per instance.
  int ecnt;
  bit started [NI];
  int kcap    [NI];
  int checks;
  int errors;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    // Model gate: output is the truth-table bit selected by {a,b,c}.
    assign d_v[gi] = g_tab[gi][{a_v[gi], b_v[gi], c_v[gi]}];

    gate3_response_checker #(
      .EXPECTED (E_TAB[gi]),
      .SETTLE   (S_TAB[gi])
    ) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start_v[gi]),
      .d                (d_v[gi]),
      .a                (a_v[gi]),
      .b                (b_v[gi]),
      .c                (c_v[gi]),
      .busy             (busy_v[gi]),
      .done             (done_v[gi]),
      .pass             (pass_v[gi]),
      .err_count        (err_v[gi]),
      .first_fail_vec   (ffv_v[gi]),
      .first_fail_valid (ffval_v[gi])
    );
  end

  function automatic int sweep_len(input int i);
    return 8 * (int'(S_TAB[i]) + 1);
  endfunction

  task automatic check(input string name, input int i, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d edge %0d: got %0h expected %0h", name, i, ecnt, act, exp);
    end
  endtask

  // Start is captured when the checker was idle after the previous edge.
  task automatic model_update();
    ecnt++;
    if (rst_n) begin
      for (int i = 0; i < NI; i++) begin
        if (start_v[i] && (!started[i] || (ecnt - kcap[i] > sweep_len(i)))) begin
          started[i] = 1'b1;
          kcap[i]    = ecnt;
        end
      end
    end
  endtask

  // Expected outputs from elapsed time since capture and the mismatch mask.
  task automatic compare_all();
    int         n;
    logic [7:0] mism;
    logic [7:0] seen;
    logic [3:0] e_err;
    logic [2:0] e_vec;
    logic [2:0] e_ffv;
    logic       e_busy, e_done, e_pass;
    for (int i = 0; i < NI; i++) begin
      n = 0;
      if (started[i]) begin
        n = (ecnt - kcap[i]) / (int'(S_TAB[i]) + 1);
        if (n > 8) n = 8;
      end
      mism   = g_tab[i] ^ E_TAB[i];
      seen   = mism & 8'((9'd1 << n) - 9'd1);
      e_err  = 4'($countones(seen));
      e_vec  = (n > 7) ? 3'd7 : 3'(n);
      e_busy = started[i] && (n < 8);
      e_done = started[i] && (ecnt - kcap[i] == sweep_len(i));
      e_pass = started[i] && (n == 8) && (e_err == 4'd0);
      e_ffv  = 3'd0;
      for (int v = 7; v >= 0; v--) if (seen[v]) e_ffv = 3'(v);
      check("abc",   i, 8'({a_v[i], b_v[i], c_v[i]}), 8'(e_vec));
      check("busy",  i, 8'(busy_v[i]),  8'(e_busy));
      check("done",  i, 8'(done_v[i]),  8'(e_done));
      check("pass",  i, 8'(pass_v[i]),  8'(e_pass));
      check("err",   i, 8'(err_v[i]),   8'(e_err));
      check("ffval", i, 8'(ffval_v[i]), 8'(seen != 8'd0));
      check("ffvec", i, 8'(ffv_v[i]),   8'(e_ffv));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) started[i] = 1'b0;
    for (int c = 0; c < cycles; c++) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input int i, output int de, output bit ok);
    ok = 1'b0;
    de = 0;
    for (int c = 0; c < 600 && !ok; c++) begin
      tick();
      if (done_v[i]) begin
        ok = 1'b1;
        de = ecnt;
      end
    end
    check("done_seen", i, 8'(ok), 8'd1);
  endtask

  // One pulsed sweep with hand-computed literal expectations at done.
  task automatic run_sweep(input int i, input logic [7:0] g, input int exp_lat,
                           input logic exp_pass, input logic [3:0] exp_err,
                           input logic exp_ffval, input logic [2:0] exp_ffv);
    int s0;
    int de;
    bit ok;
    g_tab[i]   = g;
    start_v[i] = 1'b1;
    s0         = ecnt;
    tick();
    start_v[i] = 1'b0;
    wait_done(i, de, ok);
    if (ok) begin
      check("lit_latency", i, 8'(de - (s0 + 1)), 8'(exp_lat));
      check("lit_pass",    i, 8'(pass_v[i]),  8'(exp_pass));
      check("lit_err",     i, 8'(err_v[i]),   8'(exp_err));
      check("lit_ffval",   i, 8'(ffval_v[i]), 8'(exp_ffval));
      check("lit_ffvec",   i, 8'(ffv_v[i]),   8'(exp_ffv));
    end
  endtask

  task automatic random_phase(input int iters);
    int         i;
    int         lim;
    int         rst_at;
    bit         got;
    bit         rst_done;
    logic [7:0] g;
    for (int it = 0; it < iters; it++) begin
      i        = int'($urandom_range(0, NI - 1));
      lim      = sweep_len(i);
      rst_at   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, lim - 1)) : -1;
      got      = 1'b0;
      rst_done = 1'b0;
      case ($urandom_range(0, 3))
        0:       g = E_TAB[i];
        1:       g = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
        default: g = 8'($urandom);
      endcase
      g_tab[i]   = g;
      start_v[i] = 1'b1;
      tick();
      start_v[i] = 1'b0;
      for (int c = 0; c < lim + 4 && !got && !rst_done; c++) begin
        if (rst_at > 0 && (ecnt - kcap[i] == rst_at)) begin
          do_reset(1);
          rst_done = 1'b1;
        end else begin
          // Extra start pulses only where the checker must ignore them.
          start_v[i] = (ecnt - kcap[i] < lim) ? 1'($urandom_range(0, 1)) : 1'b0;
          tick();
          if (done_v[i]) got = 1'b1;
        end
      end
      start_v[i] = 1'b0;
      if (!rst_done) check("rand_done_seen", i, 8'(got), 8'd1);
      for (int c = 0; c < int'($urandom_range(0, 2)); c++) tick();
    end
  endtask

  initial begin
    int  s0;
    int  k;
    int  de1;
    int  de2;
    bit  ok;
    checks = 0;
    errors = 0;
    ecnt   = 0;
    rst_n  = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0;
      started[i] = 1'b0;
      kcap[i]    = 0;
      g_tab[i]   = E_TAB[i];
    end
    do_reset(3);

    // Reset state, literal.
    check("rst_busy", 0, 8'(busy_v[0]), 8'd0);
    check("rst_abc",  0, 8'({a_v[0], b_v[0], c_v[0]}), 8'd0);
    check("rst_pass", 0, 8'(pass_v[0]), 8'd0);
    check("rst_err",  0, 8'(err_v[0]),  8'd0);

    // Directed sweeps against hand-derived results.
    run_sweep(0, AND3_TT, 24, 1'b1, 4'd0, 1'b0, 3'd0);
    run_sweep(0, 8'h00,   24, 1'b0, 4'd1, 1'b1, 3'd7);
    run_sweep(0, 8'hFF,   24, 1'b0, 4'd7, 1'b1, 3'd0);
    run_sweep(1, OR3_TT,  16, 1'b1, 4'd0, 1'b0, 3'd0);
    run_sweep(2, OR3_TT,  16, 1'b0, 4'd6, 1'b1, 3'd1);
    run_sweep(3, XOR3_TT, 128, 1'b1, 4'd0, 1'b0, 3'd0);

    // Reset ten edges into a sweep, then a clean sweep.
    g_tab[0]   = AND3_TT;
    start_v[0] = 1'b1;
    s0         = ecnt;
    tick();
    start_v[0] = 1'b0;
    k          = s0 + 1;
    while (ecnt < k + 10) tick();
    do_reset(1);
    check("midrst_busy", 0, 8'(busy_v[0]), 8'd0);
    check("midrst_abc",  0, 8'({a_v[0], b_v[0], c_v[0]}), 8'd0);
    check("midrst_err",  0, 8'(err_v[0]),  8'd0);
    check("midrst_done", 0, 8'(done_v[0]), 8'd0);
    for (int c = 0; c < 30; c++) tick();
    run_sweep(0, AND3_TT, 24, 1'b1, 4'd0, 1'b0, 3'd0);

    // Start held high: extras ignored, second sweep one edge after done.
    g_tab[0]   = 8'h00;
    start_v[0] = 1'b1;
    s0         = ecnt;
    wait_done(0, de1, ok);
    if (ok) begin
      check("held_latency", 0, 8'(de1 - (s0 + 1)), 8'd24);
      check("held_err1",    0, 8'(err_v[0]), 8'd1);
    end
    wait_done(0, de2, ok);
    start_v[0] = 1'b0;
    if (ok) begin
      check("held_gap",   0, 8'(de2 - de1), 8'd25);
      check("held_err2",  0, 8'(err_v[0]),  8'd1);
      check("held_ffvec", 0, 8'(ffv_v[0]),  8'd7);
      check("held_pass",  0, 8'(pass_v[0]), 8'd0);
    end
    tick();
    tick();

    random_phase(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
